// File: rtl/dp2_bias_requant_if.sv
// rtl/dp2_bias_requant_if.sv - accumulator-in / activation-out stream bundle
// slave modport is the requant stage, master is the producer/consumer side.
interface dp2_bias_requant_if #(
   parameter int ACC_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [ACC_W-1:0] in_acc;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic [5:0]       out_channel;
   logic             out_last;

   modport slave (
      input  in_valid, in_acc, in_last, out_ready,
      output in_ready, out_valid, out_data, out_channel, out_last
   );

   modport master (
      output in_valid, in_acc, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_channel, out_last
   );
endinterface

// File: rtl/dp2_bias_requant.sv
// rtl/dp2_bias_requant.sv - layer-2 bias add, round/shift, int8 saturate, optional ReLU
// Define DP2_RELU_EN to clamp negative activations to 0; otherwise signed int8 passes through.
module dp2_bias_requant #(
   parameter int ACC_W      = 32,
   parameter int NUM_CH     = 64,
   parameter int BIAS_SHIFT = 4,
   parameter int OUT_SHIFT  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   dp2_bias_requant_if.slave     bus,
   output logic [5:0]            bias_addr,
   input  logic [7:0]            bias_data,
   output logic                  err_last,
   input  logic                  err_clr
);
   localparam int SW     = ACC_W + 1;
   localparam int RW     = ACC_W + 2;
   localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam logic signed [RW-1:0] RND    = (OUT_SHIFT > 0) ? (RW'(1) << RND_SH) : '0;
   localparam logic signed [RW-1:0] SAT_HI = RW'(127);
   localparam logic signed [RW-1:0] SAT_LO = RW'(-128);
   localparam logic [5:0]           LAST_CH = 6'(NUM_CH - 1);

   logic                 r_s1_v;
   logic                 r_s2_v;
   logic signed [SW-1:0] r_s1_sum;
   logic [5:0]           r_s1_ch;
   logic                 r_s1_last;
   logic [5:0]           r_ch_cnt;
   logic [7:0]           r_out_data;
   logic [5:0]           r_out_ch;
   logic                 r_out_last;
   logic                 r_err;

   logic                 w_s2_adv;
   logic                 w_s1_adv;
   logic                 w_in_xfer;
   logic                 w_at_last;
   logic                 w_frame_err;
   logic signed [SW-1:0] w_acc_ext;
   logic signed [SW-1:0] w_bias_ext;
   logic signed [SW-1:0] w_sum;
   logic signed [RW-1:0] w_rnd;
   logic signed [7:0]    w_sat;
   logic signed [7:0]    w_act;

   assign w_s2_adv    = !r_s2_v || bus.out_ready;
   assign w_s1_adv    = !r_s1_v || w_s2_adv;
   assign w_in_xfer   = bus.in_valid && w_s1_adv;
   assign w_at_last   = (r_ch_cnt == LAST_CH);
   assign w_frame_err = w_in_xfer && (bus.in_last != w_at_last);

   assign w_acc_ext  = {bus.in_acc[ACC_W-1], bus.in_acc};
   assign w_bias_ext = {{(SW-8){bias_data[7]}}, bias_data};
   assign w_sum      = w_acc_ext + (w_bias_ext <<< BIAS_SHIFT);

   // One guard bit above the sum keeps the rounding add from wrapping.
   assign w_rnd = ($signed({r_s1_sum[SW-1], r_s1_sum}) + RND) >>> OUT_SHIFT;

   always_comb begin
      w_sat = w_rnd[7:0];
      if (w_rnd > SAT_HI) begin
         w_sat = 8'h7F;
      end else if (w_rnd < SAT_LO) begin
         w_sat = 8'h80;
      end
   end

`ifdef DP2_RELU_EN
   assign w_act = w_sat[7] ? 8'sh00 : w_sat;
`else
   assign w_act = w_sat;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ch_cnt   <= '0;
         r_s1_v     <= 1'b0;
         r_s2_v     <= 1'b0;
         r_s1_sum   <= '0;
         r_s1_ch    <= '0;
         r_s1_last  <= 1'b0;
         r_out_data <= '0;
         r_out_ch   <= '0;
         r_out_last <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         // A short or long pixel still resynchronises the counter on its last word.
         if (w_in_xfer) begin
            r_ch_cnt <= (bus.in_last || w_at_last) ? 6'd0 : r_ch_cnt + 6'd1;
         end
         if (w_s1_adv) begin
            r_s1_v <= w_in_xfer;
            if (w_in_xfer) begin
               r_s1_sum  <= w_sum;
               r_s1_ch   <= r_ch_cnt;
               r_s1_last <= bus.in_last;
            end
         end
         if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
               r_out_data <= w_act;
               r_out_ch   <= r_s1_ch;
               r_out_last <= r_s1_last;
            end
         end
         if (w_frame_err) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign bias_addr       = r_ch_cnt;
   assign bus.in_ready    = w_s1_adv;
   assign bus.out_valid   = r_s2_v;
   assign bus.out_data    = r_out_data;
   assign bus.out_channel = r_out_ch;
   assign bus.out_last    = r_out_last;
   assign err_last        = r_err;
endmodule

// File: doc/dp2_bias_requant.md
Name: dp2_bias_requant

Overview:
- Consumer stage of the depthwise-pointwise layer-2 bias ROM. It takes the pointwise MAC accumulator stream, one 32-bit word per output channel, channels 0..63 in order.
- For each word it drives the ROM address from an internal channel counter and adds the scaled int8 bias.
- It then rounds, right-shifts, saturates to int8 and applies ReLU. Results go to the next layer's activation buffer over a valid/ready stream.

Parameters:
- ACC_W, 32, accumulator width (signed).
- NUM_CH, 64, channels per pixel. Must match the bias ROM depth.
- BIAS_SHIFT, 4, left shift aligning the int8 bias to the accumulator scale.
- OUT_SHIFT, 4, requantization right shift. 0 means no rounding.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, accumulator word valid.
- in_ready, output, 1, stage can accept a word.
- in_acc, input, ACC_W, signed accumulator.
- in_last, input, 1, word is the final channel of a pixel.
- bias_addr, output, 6, bias ROM address.
- bias_data, input, 8, signed bias from the combinational ROM.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, 8, signed int8 activation.
- out_channel, output, 6, channel index of out_data.
- out_last, output, 1, final channel of a pixel.
- err_last, output, 1, sticky framing error.
- err_clr, input, 1, synchronous clear of err_last.

Behaviour:
- Reset (async assert, sync release):
  - ch_cnt=0, s1_v=0, s2_v=0.
  - out_valid=0, out_data=0, out_channel=0, out_last=0, err_last=0.
- Bias fetch: bias_addr = ch_cnt, combinational from a register. bias_data is sampled in the same cycle as the input handshake.
- Handshake:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - s2_adv = !s2_v || out_ready.
  - s1_adv = !s1_v || s2_adv.
  - in_ready = s1_adv.
  - No combinational path from in_valid to out_valid.
- Stage 1, on input transfer:
  - sum = sext(in_acc) + (sext(bias_data) <<< BIAS_SHIFT), computed in ACC_W+1 bits.
  - Register sum, ch_cnt and in_last. s1_v=1.
- Stage 2, on s2_adv with s1_v:
  - r = (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (arithmetic shift, round-half-up). r = sum when OUT_SHIFT=0.
  - Saturate r to [-128,127], then apply ReLU.
  - Register into out_data, out_channel, out_last. s2_v=1.
  - If s1_v=0 on s2_adv, s2_v becomes 0.
- Latency: 2 cycles from input transfer to out_valid, with no stalls. Sustains one word per cycle while out_ready=1.
- Channel counter:
  - Increments on each input transfer. It wraps to 0 after NUM_CH-1, or after any word with in_last=1, whichever comes first.
- Framing error: err_last is set when any of these occurs on an input transfer:
  - in_last=1 with ch_cnt != NUM_CH-1, or
  - in_last=0 with ch_cnt == NUM_CH-1.
  - The counter still resynchronises to 0 after such a word.
  - err_clr clears err_last. If set and clear happen in the same cycle, set wins.
- Backpressure: while out_ready=0, out_data, out_channel and out_last hold stable. Stage 1 fills and then in_ready drops.
- Reset mid-pixel: all in-flight words are discarded and the counter restarts at channel 0.

Optional Feature:
- DP2_RELU_EN defined: negative saturated results output as 0.
- Undefined: signed saturated result passed through, range -128..127. Used when the next layer is linear.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset, then 64 words acc=100 with the bench ROM returning bias=2 for every address → each out_data=8 ((100+32+8)>>4). out_channel runs 0..63. out_last=1 only on channel 63. bias_addr matches ch_cnt for every word.
- acc=2000, bias=16 → sum 2256, rounded 141, saturated to out_data=127. acc=-40000, bias=0, without DP2_RELU_EN → out_data=-128.
- acc=-500, bias=0 → with DP2_RELU_EN out_data=0. Without it out_data=-31.
- Streaming with out_ready toggled 1,0,0,1 per cycle → no loss or duplication of words. in_ready low when both stages are full. Outputs stable while stalled.
- in_last=1 on channel 10 → err_last=1. The next word is channel 0. err_clr pulse → err_last=0.
- Async rst asserted mid-pixel at channel 30 → out_valid=0 immediately. The next accepted word uses bias_addr=0.
